// File: rtl/tick_chk_pkg.sv
// Shared types and constants for the tick period checker.
package tick_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] ERRCNT_MAX = 8'd255;

endpackage

// File: rtl/tick_gap_counter.sv
// Elapsed-cycle counter between ticks: restarts at 1 on a tick, counts while
// running, saturates at P+1 and flags when exactly P cycles have elapsed.
module tick_gap_counter #(
    parameter int P = 4,
    parameter int W = $clog2(P + 2)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic         run,
    output logic [W-1:0] elapsed,
    output logic         at_p
);
    localparam logic [W-1:0] SAT_VAL = W'(P + 1);
    localparam logic [W-1:0] P_VAL   = W'(P);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elapsed <= '0;
        end else if (tick) begin
            elapsed <= W'(1);
        end else if (run && (elapsed != SAT_VAL)) begin
            elapsed <= elapsed + W'(1);
        end
    end

    assign at_p = (elapsed == P_VAL);

endmodule

// File: rtl/tick_period_checker.sv
// Tick period checker: measures tick spacing and locks after LOCK_CNT good periods.
// Saturating error counter is built only when TICK_PERIOD_CHECKER_ERRCNT_EN is defined.
module tick_period_checker
    import tick_chk_pkg::*;
#(
    parameter int P         = 4,
    parameter int LOCK_CNT  = 3,
    localparam int W        = $clog2(P + 2)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    output logic         locked,
    output logic         err_pulse,
    output logic [7:0]   err_count,
    output logic [W-1:0] period_out,
    output logic         period_valid
);
    localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);

    state_t       state;
    logic [3:0]   good_cnt;
    logic [W-1:0] elapsed;
    logic         at_p;
    logic         running;

    assign running = (state != IDLE);

    tick_gap_counter #(
        .P(P),
        .W(W)
    ) u_gap (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .run     (running),
        .elapsed (elapsed),
        .at_p    (at_p)
    );

    // A tick while running is always measured; only elapsed==P counts as good.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            good_cnt     <= '0;
            locked       <= 1'b0;
            err_pulse    <= 1'b0;
            period_out   <= '0;
            period_valid <= 1'b0;
        end else begin
            err_pulse    <= 1'b0;
            period_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state    <= ACQ;
                        good_cnt <= '0;
                        locked   <= 1'b0;
                    end
                end
                ACQ, LOCKED: begin
                    if (tick) begin
                        period_out   <= elapsed;
                        period_valid <= 1'b1;
                        if (at_p) begin
                            if (state == ACQ) begin
                                if (good_cnt == LOCK_LAST) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                                good_cnt <= good_cnt + 4'd1;
                            end
                        end else begin
                            err_pulse <= 1'b1;
                            state     <= ACQ;
                            good_cnt  <= '0;
                            locked    <= 1'b0;
                        end
                    end else if (at_p) begin
                        err_pulse <= 1'b1;
                        state     <= IDLE;
                        good_cnt  <= '0;
                        locked    <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    good_cnt <= '0;
                    locked   <= 1'b0;
                end
            endcase
        end
    end

`ifdef TICK_PERIOD_CHECKER_ERRCNT_EN
    logic err_event;

    // Counts the same events that raise err_pulse, so both update together.
    assign err_event = running && (tick ? !at_p : at_p);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_event && (err_count != ERRCNT_MAX)) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_tick_period_checker.sv
// Self-checking bench for tick_period_checker (P=4, LOCK_CNT=3) against a
// cycle-gap reference model; honours TICK_PERIOD_CHECKER_ERRCNT_EN.
module tb_tick_period_checker;

    localparam int P        = 4;
    localparam int LOCK_CNT = 3;
    localparam int W        = $clog2(P + 2);
`ifdef TICK_PERIOD_CHECKER_ERRCNT_EN
    localparam bit ERRCNT_EN = 1'b1;
`else
    localparam bit ERRCNT_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         tick;
    logic         locked;
    logic         err_pulse;
    logic [7:0]   err_count;
    logic [W-1:0] period_out;
    logic         period_valid;

    int checks   = 0;
    int failures = 0;

    // Reference model: counts cycles since the last tick as a plain integer.
    bit m_active;
    int m_gap;
    int m_good;
    bit m_locked;
    bit exp_err;
    bit exp_pv;
    int exp_period;
    int exp_errcnt;

    tick_period_checker #(
        .P(P),
        .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .period_out   (period_out),
        .period_valid (period_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_active   = 1'b0;
        m_gap      = 0;
        m_good     = 0;
        m_locked   = 1'b0;
        exp_err    = 1'b0;
        exp_pv     = 1'b0;
        exp_period = 0;
        exp_errcnt = 0;
    endtask

    task automatic model_step(input bit t);
        int gap;
        exp_err = 1'b0;
        exp_pv  = 1'b0;
        if (!m_active) begin
            if (t) begin
                m_active = 1'b1;
                m_gap    = 0;
                m_good   = 0;
                m_locked = 1'b0;
            end
        end else begin
            gap = m_gap + 1;
            if (t) begin
                exp_period = gap;
                exp_pv     = 1'b1;
                m_gap      = 0;
                if (gap == P) begin
                    if (!m_locked) begin
                        m_good++;
                        if (m_good >= LOCK_CNT) m_locked = 1'b1;
                    end
                end else begin
                    exp_err  = 1'b1;
                    m_good   = 0;
                    m_locked = 1'b0;
                end
            end else if (gap == P) begin
                exp_err  = 1'b1;
                m_active = 1'b0;
                m_locked = 1'b0;
                m_good   = 0;
            end else begin
                m_gap = gap;
            end
        end
        if (exp_err && ERRCNT_EN && exp_errcnt < 255) exp_errcnt++;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_output({tag, ".locked"},       32'(locked),       32'(m_locked));
        check_output({tag, ".err_pulse"},    32'(err_pulse),    32'(exp_err));
        check_output({tag, ".err_count"},    32'(err_count),    32'(exp_errcnt));
        check_output({tag, ".period_out"},   32'(period_out),   32'(exp_period));
        check_output({tag, ".period_valid"}, 32'(period_valid), 32'(exp_pv));
    endtask

    // Drive tick for one cycle, advance the model, compare 1 time unit after the edge.
    task automatic apply_stimulus(input bit t, input string tag);
        @(negedge clk);
        tick = t;
        @(posedge clk);
        model_step(t);
        #1;
        check_all(tag);
    endtask

    task automatic apply_period(input int gap, input string tag);
        for (int i = 1; i < gap; i++) apply_stimulus(1'b0, tag);
        apply_stimulus(1'b1, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        tick  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Regular ticks from reset: lock one cycle after the 4th tick.
        apply_stimulus(1'b1, "start");
        check_output("start_no_valid", 32'(period_valid), 32'd0);
        for (int i = 0; i < 3; i++) apply_period(P, "acq");
        check_output("lock_after_4th", 32'(locked), 32'd1);
        check_output("lock_period", 32'(period_out), 32'(P));
        apply_period(P, "locked_good");
        apply_period(P, "locked_good");

        // Short period while locked, then relock.
        apply_period(2, "short");
        check_output("short_err", 32'(err_pulse), 32'd1);
        check_output("short_period", 32'(period_out), 32'd2);
        check_output("short_unlock", 32'(locked), 32'd0);
        apply_stimulus(1'b0, "short_after");
        check_output("short_err_one_cycle", 32'(err_pulse), 32'd0);
        apply_period(P - 1, "relock");
        apply_period(P, "relock");
        apply_period(P, "relock");
        check_output("relock", 32'(locked), 32'd1);

        // Ticks stop: timeout error P cycles after the last tick.
        for (int i = 1; i < P; i++) apply_stimulus(1'b0, "gap");
        check_output("no_early_timeout", 32'(err_pulse), 32'd0);
        apply_stimulus(1'b0, "timeout");
        check_output("timeout_err", 32'(err_pulse), 32'd1);
        check_output("timeout_unlock", 32'(locked), 32'd0);
        check_output("timeout_no_valid", 32'(period_valid), 32'd0);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, "idle");

        // Continuous tick: one short-period error per cycle after the first.
        for (int i = 0; i < 302; i++) apply_stimulus(1'b1, "hold");
        check_output("hold_period", 32'(period_out), 32'd1);
        check_output("hold_never_locked", 32'(locked), 32'd0);
        check_output("hold_errcnt_sat", 32'(err_count), ERRCNT_EN ? 32'd255 : 32'd0);
        apply_stimulus(1'b0, "hold_end");

        // Relock, then reset asynchronously mid-period.
        apply_period(P, "pre_reset");
        for (int i = 0; i < 3; i++) apply_period(P, "pre_reset");
        check_output("pre_reset_locked", 32'(locked), 32'd1);
        apply_stimulus(1'b0, "pre_reset_mid");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(negedge clk);
        @(posedge clk);
        #1;
        check_all("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(1'b1, "post_reset_start");
        check_output("post_reset_no_err", 32'(err_pulse), 32'd0);
        for (int i = 0; i < 3; i++) apply_period(P, "post_reset");
        check_output("post_reset_lock", 32'(locked), 32'd1);

        // Randomized gaps including short, good and missing periods.
        for (int i = 0; i < 150; i++) begin
            int g;
            g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, P + 2)) : P;
            apply_period(g, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tick_period_checker.md
TICK_PERIOD_CHECKER -- requirements
Module: tick_period_checker

Interface
REQ-001 Parameter P, default 4: expected tick period in clk cycles; legal range 2..255.
REQ-002 Parameter LOCK_CNT, default 3: consecutive good periods required to lock; legal range 1..15.
REQ-003 Localparam W = clog2(P+2): width of the elapsed counter and of period_out.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset; deassertion synchronous to clk.
REQ-006 tick  input  1  tick event from a mod-counter source; each sampled-high cycle is one event.
REQ-007 locked  output  1  high while the FSM is in LOCKED.
REQ-008 err_pulse  output  1  one-cycle pulse per detected bad or missing period.
REQ-009 err_count  output  8  saturating count of err_pulse events.
REQ-010 period_out  output  W  last measured period, held until the next measurement.
REQ-011 period_valid  output  1  one-cycle pulse when period_out updates.

Function
REQ-012 FSM states IDLE, ACQ and LOCKED SHALL be used; all outputs are registered.
REQ-013 Elapsed counter: set to 1 on every sampled tick; otherwise increments each cycle while not IDLE; saturates at P+1.
REQ-014 Measured period SHALL equal elapsed at the sampling tick edge; a tick P cycles after the previous tick measures P.
REQ-015 IDLE + tick -> ACQ with good_cnt=0; no period is measured and period_valid stays low.
REQ-016 ACQ/LOCKED + tick -> period_out=elapsed and period_valid=1 on the next cycle.
REQ-017 Good period (elapsed==P) in ACQ: good_cnt+1; when it reaches LOCK_CNT -> LOCKED.
REQ-018 Good period in LOCKED: remain LOCKED with no error.
REQ-019 Short period (tick with elapsed<P): err_pulse; state -> ACQ; good_cnt=0; elapsed restarts at 1.
REQ-020 Missing tick (elapsed==P, no tick): err_pulse; state -> IDLE; period_valid stays low.
REQ-021 A tick coinciding with elapsed==P is a good period; no timeout error is raised for it.
REQ-022 Back-to-back ticks (period 1) SHALL be handled as short periods, one error per tick.
REQ-023 err_count SHALL increment with each err_pulse and saturate at 255.
REQ-024 Output latency: all responses SHALL be visible exactly one clk after the edge that sampled the causing event.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, elapsed 0, good_cnt 0, locked 0, err_pulse 0, err_count 0, period_out 0, period_valid 0.
REQ-026 Reset mid-operation SHALL discard any lock without raising err_pulse.
REQ-027 The first tick after reset SHALL be treated as the IDLE start tick.

Configuration
REQ-028 Macro TICK_PERIOD_CHECKER_ERRCNT_EN defined: err_count SHALL be implemented per REQ-023.
REQ-029 Macro TICK_PERIOD_CHECKER_ERRCNT_EN undefined: err_count SHALL be tied to 0 with no counter register; all other behaviour unchanged.

Structure
REQ-030 Package tick_chk_pkg SHALL hold the state enum (IDLE, ACQ, LOCKED) and the ERRCNT_MAX=255 constant.
REQ-031 Sub-module tick_gap_counter SHALL implement the elapsed counter, with tick restart and saturation, and flag elapsed==P.
REQ-032 The top level SHALL contain the FSM, good_cnt and the output registers.

Verification (P=4, LOCK_CNT=3)
REQ-033 Ticks every 4 cycles from reset -> locked rises 1 cycle after the 4th tick; period_out=4; err_pulse never high.
REQ-034 Locked, then one tick arrives 2 cycles after the previous tick -> err_pulse=1 for one cycle; period_out=2; locked=0; relock after 3 more good periods.
REQ-035 Locked, then ticks stop -> err_pulse 4 cycles after the last tick; state IDLE; locked=0; period_valid stays low.
REQ-036 tick held high continuously -> one err_pulse per cycle after the first; period_out=1; never locked.
REQ-037 rst_n asserted while locked, mid-period -> all outputs 0 asynchronously; the next tick restarts in ACQ with no error.
REQ-038 300 forced errors -> err_count=255 with the macro defined and 0 with it undefined.
